serial_add_sub: RTL and testbench
=================================

Name: serial_add_sub

Overview:
Bit-serial add/subtract engine built around a single full-adder cell and a carry flip-flop. It consumes one operand bit per clock, LSB first. It complements the combinational four-bit ripple adder: the same operation is done with one adder cell over WIDTH cycles, and subtraction is added. It sits behind a start/done handshake, so a controller or bench can issue operations and collect the results.

Parameters:
WIDTH, 4, operand and result width in bits (must be ≥ 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request an operation; sampled only when accepted (see Behaviour)
a  input  WIDTH  operand A, captured on accept
b  input  WIDTH  operand B, captured on accept
sub  input  1  0 = A+B, 1 = A−B; captured on accept
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: result/cout/overflow valid
result  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  carry out of the MSB; for subtraction 1 = no borrow (A ≥ B unsigned)
overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: rst sampled high at an edge forces state IDLE.
  - busy = 0, done = 0, result = 0, cout = 0, overflow = 0.
  - Internal shift registers, carry and bit counter are cleared.
  - Reset has priority over everything, including mid-operation; any partial result is discarded.
- States:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1, done = 0.
  - DONE: busy = 0, done = 1, lasts exactly one cycle.
- Accept condition: start = 1 at an edge while in IDLE or DONE. On accept:
  - opA ← a.
  - opB ← b XOR {WIDTH{sub}}.
  - carry ← sub.
  - count ← 0.
  - result ← 0, cout ← 0, overflow ← 0.
  - Next state is RUN.
- start in RUN is ignored; no queuing, and in-flight operands are unaffected.
- Each RUN edge:
  - s = opA[0] ^ opB[0] ^ carry.
  - c = majority(opA[0], opB[0], carry).
  - result shifts right with s entering the MSB.
  - opA and opB shift right.
  - carry ← c.
  - count increments.
  - On the edge processing bit WIDTH−2, latch the carry into the MSB, c_msb = c, for overflow.
- On the edge processing bit WIDTH−1:
  - cout ← c.
  - overflow ← c_msb ^ c.
  - Next state is DONE.
- Latency: start is accepted at edge E0. Bits are processed at edges E1..E_WIDTH. done is high for the cycle following E_WIDTH.
  - Back-to-back throughput is one operation per WIDTH+1 cycles.
  - A start during DONE is accepted at that edge, giving zero idle cycles.
- Output hold and visibility:
  - result, cout and overflow hold their final values from DONE through IDLE until the next accept clears them.
  - During RUN, result shows partial shifted bits and is not valid.
- Arithmetic: everything is modulo 2^WIDTH, with no saturation. The operand width is fixed, so there is no wrap of the counter beyond WIDTH−1.
- Simultaneous events: rst with start means reset wins. sub and the operands only matter at the accept edge.

Test Plan:
- WIDTH=4; after reset, check all outputs are 0. Then a=5, b=3, sub=0, pulse start → done after 4 cycles with result=8, cout=0, overflow=1; busy high for exactly 4 cycles.
- a=7, b=2, sub=1 → result=5, cout=1, overflow=0. Then a=2, b=7, sub=1 → result=11 (0xB), cout=0, overflow=0.
- a=15, b=1, sub=0 → result=0, cout=1, overflow=0. Then a=8, b=1, sub=1 → result=7, cout=1, overflow=1.
- Start a=1, b=1, sub=0. Two cycles later, raise start with a=6, b=6 → the second request is ignored. Result is 2 at done, and there is no second done without a new start.
- Hold start high continuously with fixed operands → done pulses every 5 cycles and results are identical each time. Also check result holds its value between done and the next accept when start is low.
- Assert rst for one cycle during the 3rd RUN cycle → next cycle has busy=0, done=0, result=0. No done follows. A fresh start then completes correctly (3+4 → 7).

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract engine: one full-adder cell and a carry flip-flop
// process one operand bit per clock, LSB first, behind a start/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic           carry;
    logic           c_msb;
    logic [CW-1:0]  count;
    logic           s_bit;
    logic           c_bit;

    // The single full-adder cell shared by every bit position.
    always_comb begin
        s_bit = op_a[0] ^ op_b[0] ^ carry;
        c_bit = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours (the shift chains rely on it).
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            c_msb    <= 1'b0;
            count    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        op_a     <= a;
                        op_b     <= b ^ {WIDTH{sub}};
                        carry    <= sub;
                        count    <= '0;
                        result   <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result <= {s_bit, result[WIDTH-1:1]};
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= c_bit;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 2)) begin
                        c_msb <= c_bit;
                    end
                    if (count == CW'(WIDTH - 1)) begin
                        cout     <= c_bit;
                        overflow <= c_msb ^ c_bit;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=4): directed vectors feed a
// scoreboard queue; a monitor pops and compares on every done pulse.
module tb_serial_add_sub;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .sub     (sub),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", int'(result), int'(e.result));
                    check("cout", int'(cout), int'(e.cout));
                    check("overflow", int'(overflow), int'(e.ovf));
                end
            end
        end
    end

    // Present one request for exactly one edge; optionally record its expected response.
    task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic isub,
                         input bit push, input logic [3:0] er, input logic ec, input logic eo);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        sub   = isub;
        if (push) begin
            e.result = er;
            e.cout   = ec;
            e.ovf    = eo;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done; report how many busy cycles preceded it.
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic count_dones(input int n, output int dones);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sub;
        logic [3:0] r;
        logic       c;
        logic       v;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   nb;
        int   nd;
        int   t_done[3];
        int   ndone;

        // Hand-computed: a, b, sub -> result, cout, overflow.
        vecs[0] = '{4'd5,  4'd3, 1'b0, 4'd8,  1'b0, 1'b1};
        vecs[1] = '{4'd7,  4'd2, 1'b1, 4'd5,  1'b1, 1'b0};
        vecs[2] = '{4'd2,  4'd7, 1'b1, 4'hB,  1'b0, 1'b0};
        vecs[3] = '{4'd15, 4'd1, 1'b0, 4'd0,  1'b1, 1'b0};
        vecs[4] = '{4'd8,  4'd1, 1'b1, 4'd7,  1'b1, 1'b1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_overflow", int'(overflow), 0);

        // Directed arithmetic vectors, each with a busy-length check.
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].r, vecs[i].c, vecs[i].v);
            wait_done("vec", nb);
            check("busy_cycles", nb, WIDTH);
            @(posedge clk); #1;
        end

        // A start raised while running is ignored.
        issue(4'd1, 4'd1, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; a = 4'd6; b = 4'd6; sub = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ignore", nb);
        count_dones(8, nd);
        check("no_second_done", nd, 0);

        // Start held high: back-to-back operations every WIDTH+1 cycles.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) exp_q.push_back('{4'd13, 1'b0, 1'b0});
        start = 1'b1; a = 4'd9; b = 4'd4; sub = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40 && ndone < 3; i++) begin
            @(negedge clk);
            if (done) begin
                t_done[ndone] = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        check("b2b_done_count", ndone, 3);
        if (ndone == 3) begin
            check("b2b_interval1", t_done[1] - t_done[0], WIDTH + 1);
            check("b2b_interval2", t_done[2] - t_done[1], WIDTH + 1);
        end
        repeat (3) @(negedge clk);
        check("hold_result", int'(result), 13);
        check("hold_busy", int'(busy), 0);
        check("hold_done", int'(done), 0);

        // Reset in the third RUN cycle discards the operation.
        @(posedge clk); #1;
        issue(4'd5, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_result", int'(result), 0);
        count_dones(8, nd);
        check("midrst_no_done", nd, 0);

        @(posedge clk); #1;
        issue(4'd3, 4'd4, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        wait_done("after_rst", nb);
        check("after_rst_busy_cycles", nb, WIDTH);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
